// File: rtl/crypto_job_arbiter_if.sv
// Requester and engine signal bundle for crypto_job_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface crypto_job_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 128
);
    logic [N_REQ-1:0]        req;
    logic [2*N_REQ-1:0]      req_mode;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic                    busy;
    logic [DATA_W-1:0]       eng_plaintext;
    logic [1:0]              eng_mode;
    logic                    eng_start;
    logic [DATA_W-1:0]       eng_ciphertext;
    logic                    eng_done;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_err;

    modport master (
        output req, req_mode, req_data, eng_ciphertext, eng_done,
        input  gnt, busy, eng_plaintext, eng_mode, eng_start,
               rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req, req_mode, req_data, eng_ciphertext, eng_done,
        output gnt, busy, eng_plaintext, eng_mode, eng_start,
               rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/crypto_job_arbiter.sv
// Round-robin scheduler sharing one block-cipher engine between four requesters,
// one job at a time, with a watchdog that aborts jobs the engine never finishes.
module crypto_job_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned DATA_W         = 128,
    parameter int unsigned TIMEOUT_CYCLES = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    crypto_job_arbiter_if.slave  bus
);
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   last, last_next;
    logic [IDX_W-1:0]   owner, owner_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [N_REQ-1:0]   gnt, gnt_next;
    logic [N_REQ-1:0]   rsp_valid, rsp_valid_next;
    logic               busy, busy_next;
    logic               eng_start, eng_start_next;
    logic               rsp_err, rsp_err_next;
    logic [DATA_W-1:0]  plaintext, plaintext_next;
    logic [DATA_W-1:0]  rsp_data, rsp_data_next;
    logic [1:0]         mode, mode_next;
    logic [IDX_W-1:0]   winner, cand;
    logic               found;

    // Search starts just past the last owner so it gets lowest priority.
    always_comb begin
        winner = last;
        cand   = last;
        found  = 1'b0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = last + IDX_W'(i);
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state;
        last_next      = last;
        owner_next     = owner;
        cnt_next       = cnt;
        gnt_next       = gnt;
        eng_start_next = 1'b0;
        plaintext_next = plaintext;
        mode_next      = mode;
        rsp_valid_next = '0;
        rsp_data_next  = rsp_data;
        rsp_err_next   = rsp_err;

        case (state)
            IDLE: begin
                if (found) begin
                    state_next     = ISSUE;
                    owner_next     = winner;
                    gnt_next       = N_REQ'(1) << winner;
                    plaintext_next = bus.req_data[DATA_W*winner +: DATA_W];
                    mode_next      = bus.req_mode[2*winner +: 2];
                    eng_start_next = 1'b1;
                end
            end
            ISSUE: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                // Done beats a simultaneous timeout.
                if (bus.eng_done) begin
                    rsp_data_next  = bus.eng_ciphertext;
                    rsp_err_next   = 1'b0;
                    rsp_valid_next = N_REQ'(1) << owner;
                    state_next     = RESP;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_data_next  = '0;
                    rsp_err_next   = 1'b1;
                    rsp_valid_next = N_REQ'(1) << owner;
                    state_next     = RESP;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                last_next  = owner;
                gnt_next   = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= IDX_W'(N_REQ - 1);
            owner     <= '0;
            cnt       <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            eng_start <= 1'b0;
            plaintext <= '0;
            mode      <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_next;
            last      <= last_next;
            owner     <= owner_next;
            cnt       <= cnt_next;
            gnt       <= gnt_next;
            busy      <= busy_next;
            eng_start <= eng_start_next;
            plaintext <= plaintext_next;
            mode      <= mode_next;
            rsp_valid <= rsp_valid_next;
            rsp_data  <= rsp_data_next;
            rsp_err   <= rsp_err_next;
        end
    end

    assign bus.gnt           = gnt;
    assign bus.busy          = busy;
    assign bus.eng_plaintext = plaintext;
    assign bus.eng_mode      = mode;
    assign bus.eng_start     = eng_start;
    assign bus.rsp_valid     = rsp_valid;
    assign bus.rsp_data      = rsp_data;
    assign bus.rsp_err       = rsp_err;
endmodule
